// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with load, shift, rotate, inc/dec and clear modes,
// plus a registered carry/shift-out flag and a combinational zero flag.
module universal_register #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] inp,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   one;
    assign one = {{WIDTH{1'b0}}, 1'b1};
    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        if (en) begin
            case (mode)
                3'b000:  carry_d = 1'b0;
                3'b001:  {carry_d, out_d} = {1'b0, inp};
                3'b010:  {carry_d, out_d} = {out_q, sin};
                3'b011:  {out_d, carry_d} = {sin, out_q};
                // the extra top bit of the WIDTH+1 sum/difference is the wrap flag
                3'b100:  {carry_d, out_d} = {1'b0, out_q} + one;
                3'b101:  {carry_d, out_d} = {1'b0, out_q} - one;
                3'b110:  {carry_d, out_d} = {out_q, out_q[WIDTH-1]};
                default: {carry_d, out_d} = '0;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end
    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: table-driven directed vectors plus hand-written hold and reset sequences.
module tb_universal_register;
    localparam int W = 5;
    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           INC = 3'd4, DEC = 3'd5, ROL = 3'd6, CLR = 3'd7;
    typedef struct packed {
        logic         rst;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] inp;
        logic         sin;
        logic [W-1:0] eo;
        logic         ec;
        logic         ez;
    } vec_t;
    logic clk = 1'b0, rst, en, sin, carry, zero;
    logic [2:0] mode;
    logic [W-1:0] inp, out;
    int applied = 0, bad = 0;
    vec_t tbl[$];
    universal_register #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .inp(inp), .sin(sin),
        .out(out), .carry(carry), .zero(zero)
    );
    always #5 clk = ~clk;
    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] i,
                                input logic s, input logic [W-1:0] o, input logic c, input logic z);
        mk = {r, e, m, i, s, o, c, z};
    endfunction
    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        rst = v.rst; en = v.en; mode = v.mode; inp = v.inp; sin = v.sin;
        @(posedge clk);
        #1;
        applied++;
        if ({out, carry, zero} !== {v.eo, v.ec, v.ez}) begin
            bad++;
            $display("FAIL %s: got out=%b carry=%b zero=%b, want out=%b carry=%b zero=%b",
                     name, out, carry, zero, v.eo, v.ec, v.ez);
        end
    endtask
    initial begin
        rst = 1'b1; en = 1'b0; mode = HOLD; inp = '0; sin = 1'b0;
        tbl.push_back(mk(1, 0, HOLD, 5'b00000, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(1, 1, INC,  5'b11111, 1, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, LOAD, 5'b10110, 0, 5'b10110, 0, 0));
        tbl.push_back(mk(0, 1, LOAD, 5'b11111, 0, 5'b11111, 0, 0));
        tbl.push_back(mk(0, 1, INC,  5'b00000, 0, 5'b00000, 1, 1));
        tbl.push_back(mk(0, 1, INC,  5'b00000, 0, 5'b00001, 0, 0));
        tbl.push_back(mk(0, 1, CLR,  5'b11111, 1, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, DEC,  5'b00000, 0, 5'b11111, 1, 0));
        tbl.push_back(mk(0, 1, HOLD, 5'b00000, 1, 5'b11111, 0, 0));
        tbl.push_back(mk(0, 1, LOAD, 5'b10011, 0, 5'b10011, 0, 0));
        tbl.push_back(mk(0, 1, SHL,  5'b00000, 0, 5'b00110, 1, 0));
        tbl.push_back(mk(0, 1, SHR,  5'b00000, 1, 5'b10011, 0, 0));
        tbl.push_back(mk(0, 1, ROL,  5'b00000, 0, 5'b00111, 1, 0));
        tbl.push_back(mk(0, 1, DEC,  5'b00000, 0, 5'b00110, 0, 0));
        tbl.push_back(mk(0, 1, SHR,  5'b00000, 0, 5'b00011, 0, 0));
        tbl.push_back(mk(0, 1, SHR,  5'b00000, 0, 5'b00001, 1, 0));
        tbl.push_back(mk(0, 1, SHL,  5'b00000, 1, 5'b00011, 0, 0));
        tbl.push_back(mk(0, 1, ROL,  5'b00000, 1, 5'b00110, 0, 0));
        tbl.push_back(mk(0, 1, LOAD, 5'b11111, 0, 5'b11111, 0, 0));
        tbl.push_back(mk(1, 1, INC,  5'b00000, 0, 5'b00000, 0, 1));
        tbl.push_back(mk(0, 1, LOAD, 5'b10101, 0, 5'b10101, 0, 0));
        tbl.push_back(mk(0, 1, SHL,  5'b00000, 0, 5'b01010, 1, 0));
        foreach (tbl[k]) apply($sformatf("vec%0d", k), tbl[k]);
        for (int m = 0; m < 8; m++)
            apply($sformatf("en0_mode%0d", m),
                  mk(0, 0, 3'(m), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 5'b01010, 1, 0));
        apply("hold_clears_carry", mk(0, 1, HOLD, 5'b11111, 1, 5'b01010, 0, 0));
        apply("clr_en1",           mk(0, 1, CLR,  5'b11111, 1, 5'b00000, 0, 1));
        apply("dec_wrap",          mk(0, 1, DEC,  5'b00000, 0, 5'b11111, 1, 0));
        apply("en0_keeps_carry",   mk(0, 0, INC,  5'b00000, 0, 5'b11111, 1, 0));
        apply("rst_over_inc_wrap", mk(1, 1, INC,  5'b00000, 0, 5'b00000, 0, 1));
        apply("inc_after_rst",     mk(0, 1, INC,  5'b00000, 0, 5'b00001, 0, 0));
        apply("rst_with_en0",      mk(1, 0, LOAD, 5'b10101, 0, 5'b00000, 0, 1));
        $display("== %0d vectors applied, %0d miscompares ==", applied, bad);
        $finish;
    end
endmodule
